snn_mem_bank: RTL and testbench
===============================

# snn_mem_bank

Synthesizable, parametrised on-chip memory bank for the SNN accelerator. It holds the filter kernel, per-timestep input spike maps, membrane potentials and per-timestep output spikes. It sits between the convolution/adder datapath and the testbench loader and serves read/write requests over valid/ready channels. It tracks the current timestep, flags out-of-range accesses and asserts a done indication after the final timestep.

## Interface
- F_ROWS, 3, filter rows
- F_COLS, 3, filter columns
- F_WIDTH, 8, filter weight width
- IF_ROWS, 5, input map rows
- IF_COLS, 5, input map columns
- OF_ROWS, 3, output map rows
- OF_COLS, 3, output map columns
- V_POT_WIDTH, 8, membrane potential width
- TIMESTEPS, 10, number of timesteps
- AW, 4, row/column index width
- TW, 4, timestep width (must satisfy 2^TW > TIMESTEPS)
- DW, 8, data width (must be >= F_WIDTH and >= V_POT_WIDTH)
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_valid / rd_ready  in/out  1  read request handshake
- rd_type  in  2  0=V_pot, 1=ifmap spike, 2=filter, 3=output spike
- rd_row, rd_col  in  AW  read indices
- rdata_valid / rdata_ready  out/in  1  read response handshake
- rdata  out  DW  read data, zero-extended
- wr_valid / wr_ready  in/out  1  write request handshake
- wr_type  in  2  same encoding as rd_type
- wr_row, wr_col  in  AW  write indices
- wr_t  in  TW  timestep for type-1 writes; ignored otherwise
- wr_data  in  DW  write data; bit 0 used for type 1; ignored for type 3
- t_valid / t_ready  in/out  1  timestep update handshake; t_ready is tied to 1
- t_in  in  TW  new timestep value
- t_cur  out  TW  current timestep
- done  out  1  sticky; set when a timestep >= TIMESTEPS is accepted
- err  out  1  sticky; set on an out-of-range access or a write attempted after done

## Operation
- Reset: t_cur=0, done=0, err=0, rdata_valid=0, rdata=0. All V_pot, output spike, ifmap and filter storage cleared to 0.
- Read FSM has two states:
  - IDLE: rd_ready=1. On rd_valid, capture the result, go to RESP.
  - RESP: rd_ready=0, rdata_valid=1. On rdata_ready, go to IDLE.
  - rdata holds its value until the next capture.
- Read types 1 and 3 index with t_eff = min(t_cur, TIMESTEPS-1). Reads remain allowed after done, so final output spikes can be drained.
- Writes: wr_ready = ~done. An accepted write updates storage at the clock edge.
  - Type 0 stores V_POT_WIDTH LSBs.
  - Type 1 stores wr_data[0] at [wr_t][row][col].
  - Type 2 stores F_WIDTH LSBs.
  - Type 3 sets out[t_eff][row][col]=1. It never clears the bit; the write is idempotent.
- Range check uses the bounds of the selected type; type 1 also checks wr_t < TIMESTEPS.
  - Out-of-range read: returns 0 and sets err; the handshake still completes.
  - Out-of-range write: storage is unchanged and err is set.
  - A write attempted while done=1 (wr_valid high) sets err and is not accepted.
- Timestep: an accepted t_in is loaded into t_cur. If t_in >= TIMESTEPS, done is set. t_in may move backwards (no check).
- Simultaneous read and write to the same location: the read returns the pre-write value (read-before-write).
- Simultaneous read and t update: the read uses the old t_cur.
- Simultaneous type-3 write and t update: the write uses the old t_cur.

## Timing
- Read latency: rdata_valid is asserted in the cycle after the rd_valid&rd_ready edge. Throughput is one read per 2 cycles with rdata_ready held high.
- A write is visible to a read request accepted in the next cycle.
- t_cur and done update at the edge where t_valid is high; err updates at the offending edge.
- Reset asserted mid-transaction: outputs return to reset values immediately (asynchronous); a pending response is dropped.
- Storage is plain registers; no RAM macro is inferred.

## Test plan
- Write filter (2,1)=8'h5A, read type 2 (2,1) -> rdata=8'h5A, rdata_valid one cycle after the accepting edge. Filter (0,0) reads 0 after reset.
- Write ifmap t=3 (4,4)=1, set t_in=3, read type 1 (4,4) -> 1. Set t_in=2, same read -> 0.
- Set t_in=9, write type 3 (1,2) twice, read type 3 (1,2) -> 1, (2,2) -> 0. Set t_in=10 -> done=1, t_cur=10; read (1,2) still returns 1 (t_eff=9).
- With done=1, wr_valid held high -> wr_ready=0, err=1, storage unchanged.
- Read V_pot (3,0) with OF_ROWS=3 -> rdata=0, err=1. Write filter (0,3) -> err=1, filter row 0 unchanged.
- Write V_pot (1,1)=8'h22 and read V_pot (1,1) on the same edge -> read returns 0; a following read returns 8'h22.
- Hold rdata_ready low 5 cycles -> rdata_valid stays 1, rd_ready stays 0, rdata stable.
- Assert rst_n=0 mid-RESP -> rdata_valid=0 immediately, t_cur=0, err=0, done=0, all storage reads back 0.

Source files
------------

// File: rtl/snn_mem_bank.sv
// snn_mem_bank: register-based memory bank for the SNN accelerator.
// Holds the filter kernel, per-timestep input spike maps, membrane
// potentials and per-timestep output spikes. Serves reads and writes over
// valid/ready channels, tracks the current timestep and raises sticky
// done/err flags.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   rd_valid/rd_ready, rd_type,
//   rd_row, rd_col                   read request (0=vpot 1=ifmap 2=filter 3=out spike)
//   rdata_valid/rdata_ready, rdata   read response, zero-extended
//   wr_valid/wr_ready, wr_type,
//   wr_row, wr_col, wr_t, wr_data    write request
//   t_valid/t_ready, t_in            timestep update (t_ready tied high)
//   t_cur, done, err                 current timestep and sticky status flags
//
// Read FSM:
//   state  | meaning
//   S_IDLE | rd_ready=1, waiting for a read request
//   S_RESP | rdata_valid=1, waiting for rdata_ready
module snn_mem_bank #(
  parameter int F_ROWS      = 3,
  parameter int F_COLS      = 3,
  parameter int F_WIDTH     = 8,
  parameter int IF_ROWS     = 5,
  parameter int IF_COLS     = 5,
  parameter int OF_ROWS     = 3,
  parameter int OF_COLS     = 3,
  parameter int V_POT_WIDTH = 8,
  parameter int TIMESTEPS   = 10,
  parameter int AW          = 4,
  parameter int TW          = 4,
  parameter int DW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_valid,
  output logic          rd_ready,
  input  logic [1:0]    rd_type,
  input  logic [AW-1:0] rd_row,
  input  logic [AW-1:0] rd_col,
  output logic          rdata_valid,
  input  logic          rdata_ready,
  output logic [DW-1:0] rdata,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [1:0]    wr_type,
  input  logic [AW-1:0] wr_row,
  input  logic [AW-1:0] wr_col,
  input  logic [TW-1:0] wr_t,
  input  logic [DW-1:0] wr_data,
  input  logic          t_valid,
  output logic          t_ready,
  input  logic [TW-1:0] t_in,
  output logic [TW-1:0] t_cur,
  output logic          done,
  output logic          err
);

  localparam logic [1:0] TYP_VPOT = 2'd0;
  localparam logic [1:0] TYP_IFM  = 2'd1;
  localparam logic [1:0] TYP_FILT = 2'd2;

  // Index widths just large enough to address each array dimension.
  localparam int FRB = (F_ROWS    > 1) ? $clog2(F_ROWS)    : 1;
  localparam int FCB = (F_COLS    > 1) ? $clog2(F_COLS)    : 1;
  localparam int IRB = (IF_ROWS   > 1) ? $clog2(IF_ROWS)   : 1;
  localparam int ICB = (IF_COLS   > 1) ? $clog2(IF_COLS)   : 1;
  localparam int ORB = (OF_ROWS   > 1) ? $clog2(OF_ROWS)   : 1;
  localparam int OCB = (OF_COLS   > 1) ? $clog2(OF_COLS)   : 1;
  localparam int TB  = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1;

  typedef enum logic {S_IDLE, S_RESP} rd_state_t;
  rd_state_t state;

  logic [V_POT_WIDTH-1:0] vpot [OF_ROWS][OF_COLS];
  logic                   ospk [TIMESTEPS][OF_ROWS][OF_COLS];
  logic                   ifm  [TIMESTEPS][IF_ROWS][IF_COLS];
  logic [F_WIDTH-1:0]     filt [F_ROWS][F_COLS];

  logic [TW-1:0] t_eff;
  logic [TB-1:0] t_idx;
  logic          rd_ok, wr_ok, wr_fire;
  logic [DW-1:0] rd_word;

  function automatic logic in_range(input logic [1:0] typ,
                                    input logic [AW-1:0] r,
                                    input logic [AW-1:0] c);
    case (typ)
      TYP_IFM:  return (r < AW'(IF_ROWS)) && (c < AW'(IF_COLS));
      TYP_FILT: return (r < AW'(F_ROWS))  && (c < AW'(F_COLS));
      default:  return (r < AW'(OF_ROWS)) && (c < AW'(OF_COLS));
    endcase
  endfunction

  // Past the last timestep, spike maps stay pinned to the final slot so the
  // output spikes can still be drained after done.
  assign t_eff = (t_cur > TW'(TIMESTEPS-1)) ? TW'(TIMESTEPS-1) : t_cur;
  assign t_idx = t_eff[TB-1:0];

  assign rd_ok   = in_range(rd_type, rd_row, rd_col);
  assign wr_ok   = in_range(wr_type, wr_row, wr_col) &&
                   ((wr_type != TYP_IFM) || (wr_t < TW'(TIMESTEPS)));
  assign wr_ready = ~done;
  assign wr_fire  = wr_valid & ~done;
  assign t_ready  = 1'b1;
  assign rd_ready    = (state == S_IDLE);
  assign rdata_valid = (state == S_RESP);

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      unique case (rd_type)
        TYP_VPOT: rd_word[V_POT_WIDTH-1:0] = vpot[rd_row[ORB-1:0]][rd_col[OCB-1:0]];
        TYP_IFM:  rd_word[0] = ifm[t_idx][rd_row[IRB-1:0]][rd_col[ICB-1:0]];
        TYP_FILT: rd_word[F_WIDTH-1:0] = filt[rd_row[FRB-1:0]][rd_col[FCB-1:0]];
        default:  rd_word[0] = ospk[t_idx][rd_row[ORB-1:0]][rd_col[OCB-1:0]];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      rdata <= '0;
      t_cur <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int r = 0; r < OF_ROWS; r++)
        for (int c = 0; c < OF_COLS; c++) begin
          vpot[r][c] <= '0;
          for (int t = 0; t < TIMESTEPS; t++) ospk[t][r][c] <= 1'b0;
        end
      for (int t = 0; t < TIMESTEPS; t++)
        for (int r = 0; r < IF_ROWS; r++)
          for (int c = 0; c < IF_COLS; c++) ifm[t][r][c] <= 1'b0;
      for (int r = 0; r < F_ROWS; r++)
        for (int c = 0; c < F_COLS; c++) filt[r][c] <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (rd_valid) begin
          rdata <= rd_word;
          state <= S_RESP;
        end
        S_RESP: if (rdata_ready) state <= S_IDLE;
      endcase

      // Storage is read combinationally above, so a same-edge read sees the
      // pre-write contents; type-3 writes use t_eff from the old t_cur.
      if (wr_fire && wr_ok) begin
        unique case (wr_type)
          TYP_VPOT: vpot[wr_row[ORB-1:0]][wr_col[OCB-1:0]] <= wr_data[V_POT_WIDTH-1:0];
          TYP_IFM:  ifm[wr_t[TB-1:0]][wr_row[IRB-1:0]][wr_col[ICB-1:0]] <= wr_data[0];
          TYP_FILT: filt[wr_row[FRB-1:0]][wr_col[FCB-1:0]] <= wr_data[F_WIDTH-1:0];
          default:  ospk[t_idx][wr_row[ORB-1:0]][wr_col[OCB-1:0]] <= 1'b1;
        endcase
      end

      if ((rd_valid && rd_ready && !rd_ok) || (wr_fire && !wr_ok) || (wr_valid && done))
        err <= 1'b1;

      if (t_valid) begin
        t_cur <= t_in;
        if (t_in >= TW'(TIMESTEPS)) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snn_mem_bank.sv
// Testbench for snn_mem_bank: directed vectors, a flat-array reference model
// checked against the DUT every cycle, plus literal checks on read results.
module tb_snn_mem_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rd_valid = 1'b0, rd_ready;
  logic [1:0] rd_type = '0;
  logic [3:0] rd_row = '0, rd_col = '0;
  logic       rdata_valid, rdata_ready = 1'b1;
  logic [7:0] rdata;
  logic       wr_valid = 1'b0, wr_ready;
  logic [1:0] wr_type = '0;
  logic [3:0] wr_row = '0, wr_col = '0, wr_t = '0;
  logic [7:0] wr_data = '0;
  logic       t_valid = 1'b0, t_ready;
  logic [3:0] t_in = '0, t_cur;
  logic       done, err;

  int n_cmp = 0;
  int n_bad = 0;

  snn_mem_bank dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_type(rd_type),
    .rd_row(rd_row), .rd_col(rd_col),
    .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_type(wr_type),
    .wr_row(wr_row), .wr_col(wr_col), .wr_t(wr_t), .wr_data(wr_data),
    .t_valid(t_valid), .t_ready(t_ready), .t_in(t_in), .t_cur(t_cur),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: flat arrays, 10 timesteps, 3x3 filter/output, 5x5 ifmap.
  int m_vpot [9];
  int m_filt [9];
  int m_ifm  [250];
  int m_ospk [90];
  int m_t, m_done, m_err, m_busy, m_rdata;

  function automatic int teff();
    return (m_t > 9) ? 9 : m_t;
  endfunction

  function automatic int mread(input int typ, input int r, input int c, input int t);
    case (typ)
      0: return (r < 3 && c < 3) ? m_vpot[r*3+c] : -1;
      1: return (r < 5 && c < 5) ? m_ifm[t*25+r*5+c] : -1;
      2: return (r < 3 && c < 3) ? m_filt[r*3+c] : -1;
      default: return (r < 3 && c < 3) ? m_ospk[t*9+r*3+c] : -1;
    endcase
  endfunction

  function automatic bit wvalid(input int typ, input int r, input int c, input int t);
    if (typ == 1) return r < 5 && c < 5 && t < 10;
    return r < 3 && c < 3;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t <= 0; m_done <= 0; m_err <= 0; m_busy <= 0; m_rdata <= 0;
      for (int i = 0; i < 9; i++) begin m_vpot[i] <= 0; m_filt[i] <= 0; end
      for (int i = 0; i < 250; i++) m_ifm[i] <= 0;
      for (int i = 0; i < 90; i++) m_ospk[i] <= 0;
    end else begin
      if (!m_busy) begin
        if (rd_valid) begin
          m_busy <= 1;
          m_rdata <= (mread(rd_type, rd_row, rd_col, teff()) < 0) ? 0
                     : mread(rd_type, rd_row, rd_col, teff());
          if (mread(rd_type, rd_row, rd_col, teff()) < 0) m_err <= 1;
        end
      end else if (rdata_ready) m_busy <= 0;

      if (wr_valid) begin
        if (m_done != 0) m_err <= 1;
        else if (!wvalid(wr_type, wr_row, wr_col, wr_t)) m_err <= 1;
        else case (wr_type)
          2'd0: m_vpot[wr_row*3+wr_col] <= wr_data;
          2'd1: m_ifm[wr_t*25+wr_row*5+wr_col] <= wr_data[0];
          2'd2: m_filt[wr_row*3+wr_col] <= wr_data;
          default: m_ospk[teff()*9+wr_row*3+wr_col] <= 1;
        endcase
      end

      if (t_valid) begin
        m_t <= t_in;
        if (t_in >= 10) m_done <= 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("rd_ready", rd_ready, (m_busy == 0));
    chk("rdata_valid", rdata_valid, (m_busy != 0));
    chk("rdata", rdata, m_rdata);
    chk("wr_ready", wr_ready, (m_done == 0));
    chk("t_ready", t_ready, 1);
    chk("t_cur", t_cur, m_t);
    chk("done", done, m_done);
    chk("err", err, m_err);
  end

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic rd(input logic [1:0] typ, input logic [3:0] r, input logic [3:0] c,
                    output logic [7:0] d);
    @(posedge clk); #1;
    rd_valid = 1; rd_type = typ; rd_row = r; rd_col = c;
    @(posedge clk); #1;
    rd_valid = 0;
    chk("rd_latency", rdata_valid, 1);
    d = rdata;
  endtask

  task automatic wr(input logic [1:0] typ, input logic [3:0] r, input logic [3:0] c,
                    input logic [3:0] t, input logic [7:0] dat);
    @(posedge clk); #1;
    wr_valid = 1; wr_type = typ; wr_row = r; wr_col = c; wr_t = t; wr_data = dat;
    @(posedge clk); #1;
    wr_valid = 0;
  endtask

  task automatic set_t(input logic [3:0] v);
    @(posedge clk); #1;
    t_valid = 1; t_in = v;
    @(posedge clk); #1;
    t_valid = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
  endtask

  logic [7:0] d;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_t_cur", t_cur, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    chk("rst_rd_ready", rd_ready, 1);

    // Filter write/read and reset-cleared location.
    rd(2'd2, 4'd0, 4'd0, d);  chk("filt00_rst", d, 8'h00);
    wr(2'd2, 4'd2, 4'd1, 4'd0, 8'h5A);
    rd(2'd2, 4'd2, 4'd1, d);  chk("filt21", d, 8'h5A);

    // Ifmap per timestep.
    wr(2'd1, 4'd4, 4'd4, 4'd3, 8'h01);
    set_t(4'd3);
    rd(2'd1, 4'd4, 4'd4, d);  chk("ifm_t3", d, 8'h01);
    set_t(4'd2);
    rd(2'd1, 4'd4, 4'd4, d);  chk("ifm_t2", d, 8'h00);

    // Same-edge write and read of V_pot: read sees the old value.
    @(posedge clk); #1;
    wr_valid = 1; wr_type = 2'd0; wr_row = 4'd1; wr_col = 4'd1; wr_data = 8'h22;
    rd_valid = 1; rd_type = 2'd0; rd_row = 4'd1; rd_col = 4'd1;
    @(posedge clk); #1;
    wr_valid = 0; rd_valid = 0;
    chk("rbw_old", rdata, 8'h00);
    rd(2'd0, 4'd1, 4'd1, d);  chk("rbw_new", d, 8'h22);

    // Backpressure on the response.
    rdata_ready = 0;
    rd(2'd0, 4'd1, 4'd1, d);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", rdata_valid, 1);
      chk("stall_ready", rd_ready, 0);
      chk("stall_data", rdata, 8'h22);
    end
    rdata_ready = 1;

    // Out-of-range read.
    rd(2'd0, 4'd3, 4'd0, d);
    chk("oob_rd_data", d, 8'h00);
    chk("oob_rd_err", err, 1);

    // Reset in the middle of a pending response.
    rdata_ready = 0;
    rd(2'd0, 4'd1, 4'd1, d);
    #2 rst_n = 0;
    #1;
    chk("arst_valid", rdata_valid, 0);
    chk("arst_t_cur", t_cur, 0);
    chk("arst_err", err, 0);
    chk("arst_done", done, 0);
    chk("arst_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1; rdata_ready = 1;
    rd(2'd2, 4'd2, 4'd1, d);  chk("clr_filt", d, 8'h00);
    rd(2'd0, 4'd1, 4'd1, d);  chk("clr_vpot", d, 8'h00);
    set_t(4'd3);
    rd(2'd1, 4'd4, 4'd4, d);  chk("clr_ifm", d, 8'h00);

    // Out-of-range filter write leaves row 0 intact.
    wr(2'd2, 4'd0, 4'd0, 4'd0, 8'h11);
    chk("pre_oob_wr_err", err, 0);
    wr(2'd2, 4'd0, 4'd3, 4'd0, 8'hFF);
    chk("oob_wr_err", err, 1);
    rd(2'd2, 4'd0, 4'd0, d);  chk("row0_c0", d, 8'h11);
    rd(2'd2, 4'd0, 4'd1, d);  chk("row0_c1", d, 8'h00);
    rd(2'd2, 4'd0, 4'd2, d);  chk("row0_c2", d, 8'h00);

    // Output spikes, done, and draining after done.
    pulse_reset();
    set_t(4'd9);
    wr(2'd3, 4'd1, 4'd2, 4'd0, 8'h00);
    wr(2'd3, 4'd1, 4'd2, 4'd0, 8'h00);
    rd(2'd3, 4'd1, 4'd2, d);  chk("ospk12", d, 8'h01);
    rd(2'd3, 4'd2, 4'd2, d);  chk("ospk22", d, 8'h00);
    set_t(4'd10);
    chk("done_set", done, 1);
    chk("done_t_cur", t_cur, 10);
    rd(2'd3, 4'd1, 4'd2, d);  chk("ospk_drain", d, 8'h01);

    // Writes refused after done.
    chk("pre_done_wr_err", err, 0);
    @(posedge clk); #1;
    wr_valid = 1; wr_type = 2'd2; wr_row = 4'd0; wr_col = 4'd0; wr_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("done_wr_ready", wr_ready, 0);
      chk("done_wr_err", err, 1);
    end
    wr_valid = 0;
    rd(2'd2, 4'd0, 4'd0, d);  chk("done_wr_nochange", d, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
